// File: rtl/rgy_sequencer.sv
// Traffic-light phase sequencer: drives the 4-bit RGY phase code from a prescaled
// tick, with latched per-direction green requests that can shorten the opposing green.
module rgy_sequencer #(
    parameter int unsigned TICK_DIV  = 4,
    parameter int unsigned MIN_GREEN = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [3:0] q,
    output logic       tick,
    output logic [1:0] pend,
    output logic [1:0] ack
);

    typedef enum logic [1:0] {
        G1 = 2'd0,
        Y1 = 2'd1,
        G0 = 2'd2,
        Y0 = 2'd3
    } region_t;

    localparam logic [15:0] PC_LAST = 16'(TICK_DIV - 1);
    localparam logic [3:0]  DWELL   = 4'(MIN_GREEN - 1);

    region_t     region;
    logic [15:0] pc;
    logic        step;
    logic [3:0]  q_next;
    logic [1:0]  green;
    logic [1:0]  enter;

    always_comb begin
        region = G1;
        if (q <= 4'd5)
            region = G1;
        else if (q <= 4'd7)
            region = Y1;
        else if (q <= 4'd13)
            region = G0;
        else
            region = Y0;
    end

    // Bit k of green/enter/pend/ack always refers to direction k.
    assign green = {region == G1, region == G0};
    assign step  = en && (pc == PC_LAST);

    always_comb begin
        q_next = q + 4'd1;
        if (region == G1 && pend[0] && q >= DWELL)
            q_next = 4'd6;
        if (region == G0 && pend[1] && (q - 4'd8) >= DWELL)
            q_next = 4'd14;
    end

    assign enter = {q_next == 4'd0, q_next == 4'd8} & {2{step}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc   <= '0;
            q    <= '0;
            tick <= 1'b0;
            pend <= '0;
            ack  <= '0;
        end else begin
            tick <= step;
            ack  <= enter & pend;
            if (en) begin
                pc   <= step ? '0 : pc + 16'd1;
                // Clearing on green entry takes priority over a same-edge request.
                pend <= (pend | (req & ~green)) & ~enter;
                if (step)
                    q <= q_next;
            end
        end
    end

endmodule

// File: tb/tb_rgy_sequencer.sv
// Self-checking bench for rgy_sequencer: expected step results are queued when
// stimulus is applied and compared as each tick appears.
module tb_rgy_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] req;
    logic [3:0] q;
    logic       tick;
    logic [1:0] pend;
    logic [1:0] ack;

    typedef struct packed {
        logic [3:0] q;
        logic [1:0] ack;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    rgy_sequencer #(.TICK_DIV(4), .MIN_GREEN(2)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .req  (req),
        .q    (q),
        .tick (tick),
        .pend (pend),
        .ack  (ack)
    );

    always #5 clk = ~clk;

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (tick === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        en  = 1'b1;
        req = 2'b00;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({q, pend, ack, tick} !== 9'd0) begin
            fails++;
            $display("FAIL reset_async: q=%0d pend=%b ack=%b tick=%b, need all zero", q, pend, ack, tick);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checks++;
            if (tick !== 1'b0 || q !== 4'd0) begin
                fails++;
                $display("FAIL reset_early_step edge %0d: q=%0d tick=%b, need q=0 tick=0", i, q, tick);
            end
        end
        @(negedge clk);
        checks++;
        if (q !== 4'd1 || tick !== 1'b1) begin
            fails++;
            $display("FAIL reset_first_step: q=%0d tick=%b, need q=1 tick=1", q, tick);
        end
    endtask

    task automatic test_free_run;
        int   nticks = 0;
        bit   ack_seen = 1'b0;
        exp_t e;
        for (int i = 0; i < 16; i++)
            sb.push_back('{q: 4'((2 + i) % 16), ack: 2'b00});
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (ack !== 2'b00) ack_seen = 1'b1;
            checks++;
            if (tick !== ((i % 4) == 3)) begin
                fails++;
                $display("FAIL free_tick_spacing cycle %0d: tick=%b, need %b", i, tick, (i % 4) == 3);
            end
            if (tick === 1'b1) begin
                nticks++;
                e = sb.pop_front();
                checks++;
                if (q !== e.q) begin
                    fails++;
                    $display("FAIL free_q: q=%0d, need %0d", q, e.q);
                end
            end
        end
        checks++;
        if (nticks != 16 || ack_seen || sb.size() != 0) begin
            fails++;
            $display("FAIL free_summary: ticks=%0d ack_seen=%0b left=%0d, need 16 0 0", nticks, ack_seen, sb.size());
        end
    endtask

    task automatic test_truncation;
        bit   ok;
        exp_t e;
        req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        checks++;
        if (pend !== 2'b01) begin
            fails++;
            $display("FAIL trunc_pend_set: pend=%b, need 01", pend);
        end
        sb.push_back('{q: 4'd6, ack: 2'b00});
        sb.push_back('{q: 4'd7, ack: 2'b00});
        sb.push_back('{q: 4'd8, ack: 2'b01});
        while (sb.size() != 0) begin
            wait_tick(ok);
            e = sb.pop_front();
            checks++;
            if (!ok || q !== e.q || ack !== e.ack) begin
                fails++;
                $display("FAIL trunc_step: ok=%0b q=%0d ack=%b, need q=%0d ack=%b", ok, q, ack, e.q, e.ack);
            end
        end
        checks++;
        if (pend !== 2'b00) begin
            fails++;
            $display("FAIL trunc_pend_clear: pend=%b, need 00", pend);
        end
        @(negedge clk);
        checks++;
        if (ack !== 2'b00) begin
            fails++;
            $display("FAIL trunc_ack_width: ack=%b, need 00", ack);
        end
    endtask

    task automatic test_min_dwell;
        bit   ok;
        exp_t e;
        // Entered one cycle after q became 8; pc has advanced once.
        req = 2'b10;
        @(negedge clk);
        req = 2'b00;
        checks++;
        if (pend !== 2'b10) begin
            fails++;
            $display("FAIL dwell_pend_set: pend=%b, need 10", pend);
        end
        sb.push_back('{q: 4'd9,  ack: 2'b00});
        sb.push_back('{q: 4'd14, ack: 2'b00});
        sb.push_back('{q: 4'd15, ack: 2'b00});
        sb.push_back('{q: 4'd0,  ack: 2'b10});
        while (sb.size() != 0) begin
            wait_tick(ok);
            e = sb.pop_front();
            checks++;
            if (!ok || q !== e.q || ack !== e.ack) begin
                fails++;
                $display("FAIL dwell_step: ok=%0b q=%0d ack=%b, need q=%0d ack=%b", ok, q, ack, e.q, e.ack);
            end
        end
        checks++;
        if (pend !== 2'b00) begin
            fails++;
            $display("FAIL dwell_pend_clear: pend=%b, need 00", pend);
        end
    endtask

    task automatic test_ignored_enable;
        bit   ok;
        exp_t e;
        for (int i = 1; i <= 10; i++)
            sb.push_back('{q: 4'(i), ack: 2'b00});
        while (sb.size() != 0) begin
            wait_tick(ok);
            e = sb.pop_front();
            checks++;
            if (!ok || q !== e.q || ack !== e.ack) begin
                fails++;
                $display("FAIL ign_advance: ok=%0b q=%0d ack=%b, need q=%0d ack=%b", ok, q, ack, e.q, e.ack);
            end
        end
        req = 2'b01;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (pend !== 2'b00) begin
                fails++;
                $display("FAIL ign_green_req: pend=%b, need 00", pend);
            end
        end
        req = 2'b00;
        en  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            req = (i >= 5 && i < 10) ? 2'b10 : 2'b00;
            @(negedge clk);
            checks++;
            if (q !== 4'd10 || tick !== 1'b0 || pend !== 2'b00 || ack !== 2'b00) begin
                fails++;
                $display("FAIL freeze cycle %0d: q=%0d tick=%b pend=%b ack=%b, need 10 0 00 00", i, q, tick, pend, ack);
            end
        end
        req = 2'b00;
        en  = 1'b1;
        @(negedge clk);
        checks++;
        if (q !== 4'd11 || tick !== 1'b1) begin
            fails++;
            $display("FAIL resume_pc: q=%0d tick=%b, need q=11 tick=1", q, tick);
        end
    endtask

    task automatic test_reset_mid;
        bit ack_seen = 1'b0;
        bit pend_seen = 1'b0;
        req = 2'b10;
        @(negedge clk);
        req = 2'b00;
        checks++;
        if (pend !== 2'b10 || q !== 4'd11) begin
            fails++;
            $display("FAIL mid_setup: q=%0d pend=%b, need q=11 pend=10", q, pend);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({q, pend, ack, tick} !== 9'd0) begin
            fails++;
            $display("FAIL mid_reset_async: q=%0d pend=%b ack=%b tick=%b, need all zero", q, pend, ack, tick);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ack !== 2'b00) ack_seen = 1'b1;
            if (pend !== 2'b00) pend_seen = 1'b1;
        end
        checks++;
        if (ack_seen || pend_seen || q !== 4'd10) begin
            fails++;
            $display("FAIL mid_after_release: ack_seen=%0b pend_seen=%0b q=%0d, need 0 0 10", ack_seen, pend_seen, q);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_truncation();
        test_min_dwell();
        test_ignored_enable();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
